// File: rtl/simon_pkg.sv
// Shared types and tone constants for the Simon game sound path.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam int DEF_FREQ_W = 10;
    localparam int DEF_DUR_W  = 10;

    localparam logic [DEF_FREQ_W-1:0] NOTE_G3 = 10'd196;
    localparam logic [DEF_FREQ_W-1:0] NOTE_C4 = 10'd262;
    localparam logic [DEF_FREQ_W-1:0] NOTE_E4 = 10'd330;
    localparam logic [DEF_FREQ_W-1:0] NOTE_G5 = 10'd784;

    localparam logic [DEF_FREQ_W-1:0] SUCCESS_TONES   [0:2] = '{NOTE_C4, NOTE_E4, NOTE_G5};
    localparam logic [DEF_FREQ_W-1:0] GAME_OVER_TONES [0:1] = '{NOTE_E4, NOTE_G3};

endpackage

// File: rtl/ms_timebase.sv
// Free-running millisecond tick generator; a ticks_per_milli of 0 behaves as 1.
module ms_timebase (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    output logic        ms_tick
);

    logic [15:0] count;
    logic [15:0] last;

    always_comb begin
        last = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    end

    // >= rather than == so a lowered ticks_per_milli cannot strand the count
    assign ms_tick = (count >= last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (ms_tick)
            count <= '0;
        else
            count <= count + 16'd1;
    end

endmodule

// File: rtl/tone_scheduler.sv
// Fixed-priority, preemptive sharing of the single tone generator between requesters.
module tone_scheduler
    import simon_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FREQ_W  = DEF_FREQ_W,
    parameter int DUR_W   = DEF_DUR_W,
    parameter int GAP_MS  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 ticks_per_milli,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*FREQ_W-1:0]   req_freq,
    input  logic [NUM_REQ*DUR_W-1:0]    req_dur,
    input  logic                        abort,
    output logic [FREQ_W-1:0]           freq,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          drop,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  active_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_t      state;
    logic              ms_tick;
    logic [DUR_W-1:0]  ms_left;
    logic [ID_W-1:0]   top_id;
    logic              top_any;
    logic [FREQ_W-1:0] top_freq;
    logic [DUR_W-1:0]  top_dur;
    logic              take;

    ms_timebase u_timebase (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .ms_tick         (ms_tick)
    );

    always_comb begin
        top_id  = '0;
        top_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                top_id  = ID_W'(i);
                top_any = 1'b1;
            end
        end
    end

    assign top_freq = req_freq[top_id*FREQ_W +: FREQ_W];
    assign top_dur  = req_dur[top_id*DUR_W +: DUR_W];
    // The highest pending request preempts only if it outranks the current owner
    assign take     = top_any && ((state == ST_IDLE) || (top_id > active_id));
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ms_left   <= '0;
            freq      <= '0;
            grant     <= '0;
            done      <= '0;
            drop      <= '0;
            active_id <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            drop  <= '0;
            if (abort) begin
                freq  <= '0;
                state <= ST_IDLE;
                if (state != ST_IDLE)
                    drop[active_id] <= 1'b1;
            end else if (take) begin
                if (state != ST_IDLE)
                    drop[active_id] <= 1'b1;
                grant[top_id] <= 1'b1;
                active_id     <= top_id;
                if (top_dur == '0) begin
                    done[top_id] <= 1'b1;
                    freq         <= '0;
                    state        <= ST_IDLE;
                end else begin
                    freq    <= top_freq;
                    ms_left <= top_dur;
                    state   <= ST_TONE;
                end
            end else if (ms_tick && (state != ST_IDLE)) begin
                if (ms_left <= DUR_W'(1)) begin
                    if (state == ST_TONE) begin
                        freq    <= '0;
                        ms_left <= DUR_W'(GAP_MS);
                        state   <= ST_GAP;
                    end else begin
                        done[active_id] <= 1'b1;
                        ms_left         <= '0;
                        state           <= ST_IDLE;
                    end
                end else begin
                    ms_left <= ms_left - DUR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed and randomized checks of tone_scheduler against a millisecond-level note model.
module tb_tone_scheduler;

    localparam int NR  = 4;
    localparam int FW  = 10;
    localparam int DW  = 10;
    localparam int GAP = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      tpm = 16'd4;
    logic [NR-1:0]    req = '0;
    logic [NR*FW-1:0] rf  = '0;
    logic [NR*DW-1:0] rd  = '0;
    logic             abort = 1'b0;
    logic [FW-1:0]    freq;
    logic [NR-1:0]    grant, done, drop;
    logic             busy;
    logic [1:0]       active_id;

    int total = 0;
    int bad   = 0;

    // model: notes tracked as remaining ms of tone and of gap
    int         m_n, m_len, m_hi, m_owner, m_tone, m_gap, m_freq;
    bit         m_busy, m_tick;
    logic [3:0] e_grant, e_done, e_drop;

    tone_scheduler #(.NUM_REQ(NR), .FREQ_W(FW), .DUR_W(DW), .GAP_MS(GAP)) dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (tpm),
        .req             (req),
        .req_freq        (rf),
        .req_dur         (rd),
        .abort           (abort),
        .freq            (freq),
        .grant           (grant),
        .done            (done),
        .drop            (drop),
        .busy            (busy),
        .active_id       (active_id)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            e_grant = '0;
            e_done  = '0;
            e_drop  = '0;
            if (rst) begin
                m_n = 0; m_busy = 0; m_owner = 0; m_tone = 0; m_gap = 0; m_freq = 0;
            end else begin
                m_len  = (tpm == 16'd0) ? 1 : int'(tpm);
                m_tick = ((m_n % m_len) == m_len - 1);
                m_n++;
                m_hi = -1;
                for (int i = 0; i < NR; i++) if (req[i]) m_hi = i;
                if (abort) begin
                    if (m_busy) e_drop[m_owner] = 1'b1;
                    m_busy = 0;
                    m_freq = 0;
                end else if (m_hi >= 0 && (!m_busy || m_hi > m_owner)) begin
                    if (m_busy) e_drop[m_owner] = 1'b1;
                    e_grant[m_hi] = 1'b1;
                    m_owner = m_hi;
                    m_tone  = int'(rd[m_hi*DW +: DW]);
                    m_gap   = GAP;
                    if (m_tone == 0) begin
                        e_done[m_hi] = 1'b1;
                        m_busy = 0;
                        m_freq = 0;
                    end else begin
                        m_busy = 1;
                        m_freq = int'(rf[m_hi*FW +: FW]);
                    end
                end else if (m_busy && m_tick) begin
                    if (m_tone > 0) begin
                        m_tone--;
                        if (m_tone == 0) m_freq = 0;
                    end else begin
                        m_gap--;
                        if (m_gap == 0) begin
                            e_done[m_owner] = 1'b1;
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic set_note(input int i, input int f, input int d);
        rf[i*FW +: FW] = FW'(f);
        rd[i*DW +: DW] = DW'(d);
    endtask

    task automatic do_reset(input logic [15:0] t);
        @(negedge clk);
        rst = 1'b1; req = '0; abort = 1'b0; tpm = t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (freq !== '0 || busy !== 1'b0 || grant !== '0 || done !== '0 || drop !== '0 || active_id !== '0) begin
            bad++;
            $display("FAIL power_on_reset: freq=%0d busy=%b grant=%b done=%b drop=%b id=%0d, want all 0", freq, busy, grant, done, drop, active_id);
        end
        do_reset(16'd4);
        set_note(2, 330, 5);
        req = 4'b0100;
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL reset_pre_grant: got %b want 0100", grant); end
        @(negedge clk); req = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (freq !== '0 || busy !== 1'b0 || grant !== '0 || done !== '0 || drop !== '0 || active_id !== '0) begin
            bad++;
            $display("FAIL async_reset: freq=%0d busy=%b grant=%b done=%b drop=%b id=%0d, want all 0", freq, busy, grant, done, drop, active_id);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_note();
        int hi, lo;
        bit seen;
        do_reset(16'd4);
        set_note(0, 262, 3);
        req = 4'b0001;
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0001 || freq !== 10'd262) begin
            bad++; $display("FAIL single_grant: grant=%b freq=%0d want 0001/262", grant, freq);
        end
        @(negedge clk); req = '0;
        hi = 1; lo = 0; seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done[0]) begin seen = 1; break; end
            if (freq == 10'd262) hi++;
            else if (busy) lo++;
        end
        total++;
        if (!seen || hi < 9 || hi > 12 || lo < 5 || lo > 8) begin
            bad++; $display("FAIL single_timing: done=%b tone=%0d gap=%0d want 1, 9..12, 5..8", seen, hi, lo);
        end
        total++;
        if (busy !== 1'b0 || done !== 4'b0001) begin
            bad++; $display("FAIL single_done: busy=%b done=%b want 0/0001", busy, done);
        end
    endtask

    task automatic test_priority();
        bit seen;
        do_reset(16'd4);
        set_note(1, 196, 1);
        set_note(2, 330, 1);
        req = 4'b0110;
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL priority_grant: got %b want 0100", grant); end
        @(negedge clk); req = 4'b0010;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done[2]) begin seen = 1; break; end
        end
        total++;
        if (!seen || grant !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL priority_done: done_seen=%b grant=%b busy=%b want 1/0000/0", seen, grant, busy);
        end
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0010 || freq !== 10'd196) begin
            bad++; $display("FAIL priority_second: grant=%b freq=%0d want 0010/196", grant, freq);
        end
        @(negedge clk); req = '0;
    endtask

    task automatic test_preempt();
        bit seen, early;
        do_reset(16'd4);
        set_note(0, 262, 10);
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        set_note(3, 622, 3);
        req = 4'b1000;
        @(posedge clk); #1;
        total++;
        if (drop !== 4'b0001 || grant !== 4'b1000 || freq !== 10'd622 || done !== '0 || active_id !== 2'd3) begin
            bad++;
            $display("FAIL preempt_edge: drop=%b grant=%b freq=%0d done=%b id=%0d want 0001/1000/622/0000/3", drop, grant, freq, done, active_id);
        end
        @(negedge clk);
        set_note(1, 330, 1);
        req = 4'b0010;
        seen = 0; early = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (done[3]) begin seen = 1; break; end
            if (grant !== '0) early = 1;
        end
        total++;
        if (!seen || early) begin
            bad++; $display("FAIL preempt_low_waits: done3=%b early_grant=%b want 1/0", seen, early);
        end
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0010) begin bad++; $display("FAIL preempt_follow: got %b want 0010", grant); end
        @(negedge clk); req = '0;
    endtask

    task automatic test_abort();
        bit seen;
        do_reset(16'd4);
        set_note(1, 330, 1);
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk); req = '0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (busy && freq == '0) begin seen = 1; break; end
        end
        @(negedge clk);
        abort = 1'b1;
        set_note(2, 196, 1);
        req = 4'b0100;
        @(posedge clk); #1;
        total++;
        if (!seen || drop !== 4'b0010 || grant !== '0 || freq !== '0 || busy !== 1'b0 || done !== '0) begin
            bad++;
            $display("FAIL abort_gap: in_gap=%b drop=%b grant=%b freq=%0d busy=%b done=%b want 1/0010/0000/0/0/0000", seen, drop, grant, freq, busy, done);
        end
        @(negedge clk); abort = 1'b0;
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0100 || freq !== 10'd196) begin
            bad++; $display("FAIL abort_next: grant=%b freq=%0d want 0100/196", grant, freq);
        end
        @(negedge clk); req = '0;
    endtask

    task automatic test_boundaries();
        int nb, nf;
        bit loud, seen;
        do_reset(16'd4);
        set_note(0, 196, 0);
        req = 4'b0001;
        @(posedge clk); #1;
        total++;
        if (grant !== 4'b0001 || done !== 4'b0001 || freq !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL dur_zero: grant=%b done=%b freq=%0d busy=%b want 0001/0001/0/0", grant, done, freq, busy);
        end
        @(negedge clk);
        set_note(1, 0, 2);
        req = 4'b0010;
        @(posedge clk); #1;
        @(negedge clk); req = '0;
        nb = (busy) ? 1 : 0; loud = (freq !== '0); seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done[1]) begin seen = 1; break; end
            if (busy) nb++;
            if (freq !== '0) loud = 1;
        end
        total++;
        if (!seen || loud || nb < 13 || nb > 16) begin
            bad++; $display("FAIL timed_rest: done=%b loud=%b busy_cycles=%0d want 1/0/13..16", seen, loud, nb);
        end
        do_reset(16'd0);
        set_note(0, 784, 3);
        req = 4'b0001;
        @(posedge clk); #1;
        @(negedge clk); req = '0;
        nb = (busy) ? 1 : 0; nf = (freq == 10'd784) ? 1 : 0; seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done[0]) begin seen = 1; break; end
            if (busy) nb++;
            if (freq == 10'd784) nf++;
        end
        total++;
        if (!seen || nb != 5 || nf != 3) begin
            bad++; $display("FAIL tpm_zero: done=%b busy_cycles=%0d tone_cycles=%0d want 1/5/3", seen, nb, nf);
        end
    endtask

    task automatic test_random(input int cycles);
        do_reset(16'($urandom_range(5)));
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(7) == 0) begin
                    req[i] = ~req[i];
                    if (req[i]) set_note(i, int'($urandom_range(1023)), int'($urandom_range(4)));
                end else if ($urandom_range(15) == 0) begin
                    set_note(i, int'($urandom_range(1023)), int'($urandom_range(4)));
                end
            end
            abort = ($urandom_range(39) == 0);
            @(posedge clk); #1;
            total++;
            if (freq !== FW'(m_freq)) begin bad++; $display("FAIL rand_freq c=%0d: got %0d want %0d", c, freq, m_freq); end
            total++;
            if (grant !== e_grant) begin bad++; $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, e_grant); end
            total++;
            if (done !== e_done) begin bad++; $display("FAIL rand_done c=%0d: got %b want %b", c, done, e_done); end
            total++;
            if (drop !== e_drop) begin bad++; $display("FAIL rand_drop c=%0d: got %b want %b", c, drop, e_drop); end
            total++;
            if (busy !== m_busy) begin bad++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, m_busy); end
            total++;
            if (active_id !== 2'(m_owner)) begin bad++; $display("FAIL rand_id c=%0d: got %0d want %0d", c, active_id, m_owner); end
        end
        @(negedge clk);
        req = '0; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_priority();
        test_preempt();
        test_abort();
        test_boundaries();
        for (int s = 0; s < 4; s++) test_random(500);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Shares the single square-wave tone generator (`play`) between several sound requesters in the Simon game: game-tone playback, user-feedback tones, the success jingle and the game-over jingle. Each requester submits one note at a time (frequency + duration in ms). The scheduler arbitrates by fixed priority with preemption, times the note and a trailing silence gap from its own millisecond timebase, and drives `play`'s `freq` input.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters. Index `NUM_REQ-1` has the highest priority.
- `FREQ_W`, 10: frequency width in Hz, matching `play.freq`.
- `DUR_W`, 10: note duration width in ms.
- `GAP_MS`, 20: silence inserted after every completed note, in ms. Must be ≥1.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `ticks_per_milli`  in  16: clock cycles per ms. A value of 0 is treated as 1.
- `req`  in  NUM_REQ: level request per requester. Held until `grant` or until the requester withdraws.
- `req_freq`  in  NUM_REQ*FREQ_W: packed frequencies, requester i at `[i*FREQ_W +: FREQ_W]`. A value of 0 is a timed rest.
- `req_dur`  in  NUM_REQ*DUR_W: packed durations in ms, same packing.
- `abort`  in  1: cancel the current note and return to idle.
- `freq`  out  FREQ_W: registered; connects to `play.freq`.
- `grant`  out  NUM_REQ: one-cycle one-hot pulse when a note is accepted.
- `done`  out  NUM_REQ: one-cycle pulse when the granted note and its gap complete.
- `drop`  out  NUM_REQ: one-cycle pulse when the granted note is preempted or aborted.
- `busy`  out  1: high in TONE or GAP.
- `active_id`  out  clog2(NUM_REQ): index of the current owner; holds its last value when idle.

## Operation
- Timebase: a free-running counter runs 0..max(ticks_per_milli,1)-1 and emits `ms_tick` on wrap. It is never reset by note events.
- FSM states: IDLE, TONE, GAP.
- **IDLE**, at least one `req` bit set (and `abort` low):
  - Grant the highest set index j.
  - Capture `req_freq[j]` and `req_dur[j]`; set `freq` to the captured frequency, `active_id` to j, pulse `grant[j]`.
  - Load the ms counter with the duration and go to TONE.
  - Duration 0: pulse `grant[j]` and `done[j]` on the same edge, `freq` stays 0, stay in IDLE.
- **TONE**: decrement the ms counter on each `ms_tick`. When it reaches 0, set `freq` to 0, load `GAP_MS` and go to GAP.
- **GAP**: decrement on each `ms_tick`. At 0, pulse `done[active_id]` and go to IDLE.
- Preemption, in TONE or GAP, when `req[k]` is set for some k > `active_id`:
  - Pulse `drop[active_id]`.
  - Grant the highest such k exactly as from IDLE and enter TONE.
  - Requests with index ≤ `active_id` wait.
- `abort` in any state:
  - Set `freq` to 0 and go to IDLE.
  - If busy, pulse `drop[active_id]`.
  - `abort` beats any same-cycle request and any same-cycle completion: no `grant`, no `done`.
- Completion and preemption on the same edge: preemption wins. Pulse `drop`, not `done`.
- Requester changing `req_freq`/`req_dur` after grant: no effect.
- Withdrawing `req` before grant: allowed, no response.
- Withdrawing `req` after grant: ignored.
- Arithmetic: counters are DUR_W bits, saturating at 0. `GAP_MS` must fit in DUR_W.

## Timing
- Reset values: `freq`=0, `grant`=0, `done`=0, `drop`=0, `busy`=0, `active_id`=0, state IDLE, timebase count 0.
- Grant latency: `req` sampled at edge N gives `grant`, `freq`, `busy` valid after edge N.
- Tone length: ends on the dur-th `ms_tick` strictly after the grant edge. Audible length lies in (dur-1, dur] ms.
- Gap length: same rule with `GAP_MS`.
- Back-to-back notes: after `done`, the FSM is in IDLE for ≥1 cycle before the next `grant`.
- Preemption latency: 1 edge. `drop` and `grant` occur on the same edge, and `freq` switches directly with no silent cycle.
- Reset mid-note: all outputs go to reset values immediately, asynchronously. No `drop` or `done` is emitted.

## Structure
- Shared package `simon_pkg`:
  - state encoding for IDLE/TONE/GAP;
  - tone constants (G3 196, C4 262, E4 330, G5 784, success and game-over tables);
  - `FREQ_W`/`DUR_W` defaults.
- Sub-module `ms_timebase`: inputs `clk`, `rst`, `ticks_per_milli`; output `ms_tick`. Reused by the game FSM.
- The arbiter is a fixed-priority encoder inside `tone_scheduler`. It is not a separate module.

## Test plan
All scenarios use `ticks_per_milli`=4 and `GAP_MS`=2.
- **Reset:** assert `rst` asynchronously mid-TONE → all outputs 0 before the next edge.
- **Single note:** `req[0]` with freq 262, dur 3 → `grant[0]` one cycle after the request; `freq`=262 for 9–12 cycles, then 0 for 5–8 cycles; then `done[0]`, `busy` low.
- **Priority:** `req[1]` and `req[2]` asserted together → only `grant[2]`. After `done[2]`, `grant[1]` follows ≥1 idle cycle later.
- **Preemption:** `req[3]` (freq 622) arrives during `req[0]`'s TONE → same edge gives `drop[0]`, `grant[3]`, `freq`=622, with no `done[0]`. A later `req[1]` during requester 3's TONE is not granted until requester 3 finishes.
- **Abort:** assert `abort` during GAP together with `req[2]` → `drop[active]`, no grant, `freq`=0, IDLE. `grant[2]` comes on the next edge.
- **Boundaries:**
  - dur=0 → `grant` and `done` pulse on the same edge, `freq` stays 0.
  - freq=0, dur=2 → rest is timed with `busy` high.
  - `ticks_per_milli`=0 → `ms_tick` every cycle.
